regfile_alu_pipe: RTL and testbench

- Parametrised successor of the 16-register / 16-bit register-file + ALU datapath.
- Adds generic data width and register count, a registered execute stage, a registered writeback with operand forwarding, a persistent flag register, and an external load port with ready/valid handshake.
- Sits between the control FSM / decoder and memory interface; the decoder issues one ALU op per cycle, and memory loads enter through the ld port.

---
 rtl/regfile_alu_pkg.sv | 29 ++
 rtl/regfile_alu_pipe_alu_core.sv | 83 ++++++++
 rtl/regfile_alu_pipe.sv | 93 +++++++++
 tb/tb_regfile_alu_pipe.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_alu_pkg.sv
// Shared opcode encodings, flag bit positions and the flag-vector type for the
// register-file / ALU pipeline.
package regfile_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_CMP = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_LSH = 4'd7;
  localparam logic [3:0] OP_RSH = 4'd8;
  localparam logic [3:0] OP_NOP = 4'd15;

  localparam int FLG_C = 4;
  localparam int FLG_L = 3;
  localparam int FLG_F = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 0;

  typedef logic [4:0] flags_t;

  // Every defined op except CMP writes its destination; 9..15 are NOPs.
  function automatic logic op_writes(input logic [3:0] op);
    return (op <= OP_RSH) && (op != OP_CMP);
  endfunction

endpackage

// File: rtl/regfile_alu_pipe_alu_core.sv
// Combinational ALU: produces the result plus a mask of which flags the op
// touches and the new values for those flags.
module alu_core
  import regfile_alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output flags_t            flag_mask,
  output flags_t            flag_val
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic            add_ovf;
  logic            sub_ovf;
  logic            lt_s;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign add_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
  assign sub_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
  assign lt_s    = $signed(a) < $signed(b);

  always_comb begin
    result    = '0;
    flag_mask = '0;
    flag_val  = '0;
    case (op)
      OP_ADD: begin
        result           = sum[DATA_W-1:0];
        flag_mask[FLG_C] = 1'b1;
        flag_mask[FLG_F] = 1'b1;
        flag_mask[FLG_Z] = 1'b1;
        flag_val[FLG_C]  = sum[DATA_W];
        flag_val[FLG_F]  = add_ovf;
      end
      OP_SUB, OP_CMP: begin
        // The borrow out of the wide difference is exactly unsigned A<B.
        result          = diff[DATA_W-1:0];
        flag_mask       = '1;
        flag_val[FLG_C] = diff[DATA_W];
        flag_val[FLG_L] = diff[DATA_W];
        flag_val[FLG_F] = sub_ovf;
        flag_val[FLG_N] = lt_s;
      end
      OP_AND: begin
        result           = a & b;
        flag_mask[FLG_Z] = 1'b1;
      end
      OP_OR: begin
        result           = a | b;
        flag_mask[FLG_Z] = 1'b1;
      end
      OP_XOR: begin
        result           = a ^ b;
        flag_mask[FLG_Z] = 1'b1;
      end
      OP_MOV: begin
        result = b;
      end
      OP_LSH: begin
        result           = a << b[SH_W-1:0];
        flag_mask[FLG_Z] = 1'b1;
      end
      OP_RSH: begin
        result           = a >> b[SH_W-1:0];
        flag_mask[FLG_Z] = 1'b1;
      end
      default: begin
        result = '0;
      end
    endcase
    // For CMP the difference is zero exactly when A == B.
    flag_val[FLG_Z] = (result == '0);
  end

endmodule

// File: rtl/regfile_alu_pipe.sv
// Register file with a registered ALU execute stage, writeback forwarding,
// persistent flags and a ready/valid external load port.
module regfile_alu_pipe
  import regfile_alu_pkg::*;
#(
  parameter  int DATA_W   = 16,
  parameter  int NUM_REGS = 16,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  input  logic [3:0]        OpCode,
  input  logic [ADDR_W-1:0] RdestLoc,
  input  logic [ADDR_W-1:0] RsrcLoc,
  input  logic              Imm_s,
  input  logic [DATA_W-1:0] Imm,
  output logic              out_valid,
  output logic [DATA_W-1:0] Result,
  output flags_t            Flags,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              wb_valid;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;

  logic              wb_pending;
  logic              fwd_a;
  logic              fwd_b;
  logic              ld_fire;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] alu_result;
  flags_t            alu_mask;
  flags_t            alu_val;

  assign wb_pending = wb_valid & wb_we;
  assign fwd_a      = wb_pending && (wb_addr == RdestLoc);
  assign fwd_b      = wb_pending && (wb_addr == RsrcLoc);

  assign opa = fwd_a ? Result : regs[RdestLoc];
  assign opb = Imm_s ? Imm : (fwd_b ? Result : regs[RsrcLoc]);

  // Loads are only accepted when no writeback is due, so the two write
  // sources never meet on the same edge.
  assign ld_ready  = ~wb_pending;
  assign ld_fire   = ld_valid & ld_ready;
  assign out_valid = wb_valid;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a         (opa),
    .b         (opb),
    .op        (OpCode),
    .result    (alu_result),
    .flag_mask (alu_mask),
    .flag_val  (alu_val)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_addr  <= '0;
      Result   <= '0;
      Flags    <= '0;
    end else begin
      wb_valid <= in_valid;
      wb_we    <= in_valid & op_writes(OpCode);
      if (in_valid) begin
        wb_addr <= RdestLoc;
        Result  <= alu_result;
        Flags   <= (Flags & ~alu_mask) | (alu_val & alu_mask);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_pending) begin
      regs[wb_addr] <= Result;
    end else if (ld_fire) begin
      regs[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Directed bench for regfile_alu_pipe: a table of back-to-back ops with
// hand-computed results and flags, plus load-port and reset sequences.
module tb_regfile_alu_pipe;

  logic        Clk;
  logic        Rst;
  logic        in_valid;
  logic [3:0]  OpCode;
  logic [3:0]  RdestLoc;
  logic [3:0]  RsrcLoc;
  logic        Imm_s;
  logic [15:0] Imm;
  logic        out_valid;
  logic [15:0] Result;
  logic [4:0]  Flags;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_addr;
  logic [15:0] ld_data;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_alu_pipe #(.DATA_W(16), .NUM_REGS(16)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .OpCode    (OpCode),
    .RdestLoc  (RdestLoc),
    .RsrcLoc   (RsrcLoc),
    .Imm_s     (Imm_s),
    .Imm       (Imm),
    .out_valid (out_valid),
    .Result    (Result),
    .Flags     (Flags),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic        s;
    logic [15:0] imm;
    logic        chk_res;
    logic [15:0] res;
    logic [4:0]  flg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [3:0] rd,
                              input logic [3:0] rs, input logic s,
                              input logic [15:0] imm, input logic chk_res,
                              input logic [15:0] res, input logic [4:0] flg);
    vec_t v;
    v.op = op; v.rd = rd; v.rs = rs; v.s = s; v.imm = imm;
    v.chk_res = chk_res; v.res = res; v.flg = flg;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic s, input logic [15:0] imm);
    in_valid = 1'b1; OpCode = op; RdestLoc = rd; RsrcLoc = rs; Imm_s = s; Imm = imm;
  endtask

  task automatic idle();
    in_valid = 1'b0; OpCode = 4'd0; RdestLoc = 4'd0; RsrcLoc = 4'd0; Imm_s = 1'b0; Imm = 16'h0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [15:0] res, input logic [4:0] flg);
    check({name, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, " result"}, {16'd0, Result}, {16'd0, res});
    check({name, " flags"}, {27'd0, Flags}, {27'd0, flg});
  endtask

  task automatic do_load(input logic [3:0] addr, input logic [15:0] data);
    ld_valid = 1'b1; ld_addr = addr; ld_data = data;
    #1;
    check("ld_ready idle", {31'd0, ld_ready}, 32'd1);
    step();
    ld_valid = 1'b0;
  endtask

  initial begin
    // {op, rd, rs, imm_s, imm, check result, result, flags {C,L,F,Z,N}}
    vecs.push_back(mk(4'd0,  4'd1,  4'd2, 1'b0, 16'h0000, 1'b1, 16'h0008, 5'b00000)); // ADD R1,R2
    vecs.push_back(mk(4'd6,  4'd15, 4'd1, 1'b0, 16'h0000, 1'b1, 16'h0008, 5'b00000)); // MOV R15,R1 (fwd)
    vecs.push_back(mk(4'd6,  4'd1,  4'd0, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 5'b00000));
    vecs.push_back(mk(4'd0,  4'd1,  4'd0, 1'b1, 16'h0001, 1'b1, 16'h0000, 5'b10010)); // wrap
    vecs.push_back(mk(4'd0,  4'd1,  4'd0, 1'b1, 16'h0001, 1'b1, 16'h0001, 5'b00000));
    vecs.push_back(mk(4'd6,  4'd3,  4'd0, 1'b1, 16'h8000, 1'b1, 16'h8000, 5'b00000));
    vecs.push_back(mk(4'd6,  4'd4,  4'd0, 1'b1, 16'h0001, 1'b1, 16'h0001, 5'b00000));
    vecs.push_back(mk(4'd2,  4'd3,  4'd4, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'b00101)); // CMP
    vecs.push_back(mk(4'd6,  4'd15, 4'd3, 1'b0, 16'h0000, 1'b1, 16'h8000, 5'b00101)); // R3 kept
    vecs.push_back(mk(4'd3,  4'd4,  4'd3, 1'b0, 16'h0000, 1'b1, 16'h0000, 5'b00111)); // AND
    vecs.push_back(mk(4'd6,  4'd5,  4'd0, 1'b1, 16'h7FFF, 1'b1, 16'h7FFF, 5'b00111));
    vecs.push_back(mk(4'd1,  4'd5,  4'd0, 1'b1, 16'hFFFF, 1'b1, 16'h8000, 5'b11100)); // SUB ovf
    vecs.push_back(mk(4'd12, 4'd5,  4'd0, 1'b1, 16'h1234, 1'b1, 16'h0000, 5'b11100)); // NOP
    vecs.push_back(mk(4'd6,  4'd15, 4'd5, 1'b0, 16'h0000, 1'b1, 16'h8000, 5'b11100));
    vecs.push_back(mk(4'd5,  4'd5,  4'd0, 1'b1, 16'h8000, 1'b1, 16'h0000, 5'b11110)); // XOR
    vecs.push_back(mk(4'd4,  4'd5,  4'd0, 1'b1, 16'h00F0, 1'b1, 16'h00F0, 5'b11100)); // OR
    vecs.push_back(mk(4'd7,  4'd5,  4'd0, 1'b1, 16'h0014, 1'b1, 16'h0F00, 5'b11100)); // LSH by 4
    vecs.push_back(mk(4'd8,  4'd5,  4'd0, 1'b1, 16'h0008, 1'b1, 16'h000F, 5'b11100)); // RSH by 8
    vecs.push_back(mk(4'd8,  4'd5,  4'd0, 1'b1, 16'h000F, 1'b1, 16'h0000, 5'b11110)); // RSH by 15
    vecs.push_back(mk(4'd0,  4'd6,  4'd0, 1'b1, 16'h0000, 1'b1, 16'h0000, 5'b01010));

    Rst = 1'b0;
    idle();
    ld_valid = 1'b0; ld_addr = 4'd0; ld_data = 16'h0;
    #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset result", {16'd0, Result}, 32'd0);
    check("reset flags", {27'd0, Flags}, 32'd0);
    check("reset ld_ready", {31'd0, ld_ready}, 32'd1);
    @(posedge Clk);
    @(posedge Clk);
    #3 Rst = 1'b1;
    step();

    do_load(4'd1, 16'h0005);
    do_load(4'd2, 16'h0003);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].s, vecs[i].imm);
      step();
      check($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      if (vecs[i].chk_res)
        check($sformatf("v%0d result", i), {16'd0, Result}, {16'd0, vecs[i].res});
      check($sformatf("v%0d flags", i), {27'd0, Flags}, {27'd0, vecs[i].flg});
    end

    idle();
    step();
    check("idle out_valid", {31'd0, out_valid}, 32'd0);
    check("idle flags", {27'd0, Flags}, 32'h0A);

    // Load held during an ADD issue: refused while a writeback is due.
    issue(4'd6, 4'd9, 4'd0, 1'b1, 16'h0AAA);
    step();
    expect_out("mov r9", 16'h0AAA, 5'b01010);
    issue(4'd0, 4'd8, 4'd0, 1'b1, 16'h0055);
    ld_valid = 1'b1; ld_addr = 4'd7; ld_data = 16'h1234;
    #1;
    check("ld_ready issue", {31'd0, ld_ready}, 32'd0);
    step();
    expect_out("add r8", 16'h0055, 5'b01000);
    idle();
    #1;
    check("ld_ready wb", {31'd0, ld_ready}, 32'd0);
    begin
      int waited = 0;
      while (!ld_ready && waited < 5) begin
        step();
        waited++;
      end
      check("ld accept cycle", waited, 1);
    end
    issue(4'd6, 4'd15, 4'd7, 1'b0, 16'h0000);
    step();
    ld_valid = 1'b0;
    expect_out("ld same-cycle read", 16'h0000, 5'b01000);
    issue(4'd6, 4'd15, 4'd7, 1'b0, 16'h0000);
    step();
    expect_out("read r7", 16'h1234, 5'b01000);
    issue(4'd6, 4'd15, 4'd8, 1'b0, 16'h0000);
    step();
    expect_out("read r8", 16'h0055, 5'b01000);

    // Reset lands while an op sits in writeback.
    issue(4'd0, 4'd9, 4'd0, 1'b1, 16'h0001);
    step();
    expect_out("add r9", 16'h0AAB, 5'b01000);
    idle();
    #1 Rst = 1'b0;
    #1;
    check("mid reset out_valid", {31'd0, out_valid}, 32'd0);
    check("mid reset result", {16'd0, Result}, 32'd0);
    check("mid reset flags", {27'd0, Flags}, 32'd0);
    @(posedge Clk);
    #2 Rst = 1'b1;
    step();
    issue(4'd6, 4'd15, 4'd9, 1'b0, 16'h0000);
    step();
    expect_out("post reset r9", 16'h0000, 5'b00000);
    issue(4'd6, 4'd15, 4'd1, 1'b0, 16'h0000);
    step();
    expect_out("post reset r1", 16'h0000, 5'b00000);
    issue(4'd6, 4'd15, 4'd7, 1'b0, 16'h0000);
    step();
    expect_out("post reset r7", 16'h0000, 5'b00000);
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
